vga_timing_gen: RTL and testbench



---
 rtl/vga_timing_gen.sv | 121 ++++++++++++
 tb/tb_vga_timing_gen.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// vga_timing_gen
// Raster timing generator for a 640x480@60 VGA display (800x525 total).
// Produces the current pixel coordinate, sync pulses, the visible-area flag
// and one-clock line/frame strobes for the pong renderer.
//
// Ports:
//   clk          system clock
//   rst          synchronous reset, active-high (dominates en)
//   en           pixel-clock enable; the raster advances only when en=1
//   hpos[9:0]    current horizontal position, 0..H_TOTAL-1
//   vpos[9:0]    current vertical position, 0..V_TOTAL-1
//   hsync        horizontal sync, asserted level = HSYNC_POL
//   vsync        vertical sync, asserted level = VSYNC_POL
//   display_on   high while the position is inside the visible area
//   line_start   one-clock pulse on the enabled edge that loads hpos=0
//   frame_start  one-clock pulse on the enabled edge that loads (0,0)
//
// Every output is a flop. Sync and display flags are computed from the next
// counter values, so they always line up with hpos/vpos in the same cycle.

module vga_timing_gen #(
    parameter int unsigned H_ACTIVE  = 640,
    parameter int unsigned H_FP      = 16,
    parameter int unsigned H_SYNC    = 96,
    parameter int unsigned H_BP      = 48,
    parameter int unsigned V_ACTIVE  = 480,
    parameter int unsigned V_FP      = 10,
    parameter int unsigned V_SYNC    = 2,
    parameter int unsigned V_BP      = 33,
    parameter bit          HSYNC_POL = 1'b0,
    parameter bit          VSYNC_POL = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    output logic [9:0] hpos,
    output logic [9:0] vpos,
    output logic       hsync,
    output logic       vsync,
    output logic       display_on,
    output logic       line_start,
    output logic       frame_start
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    // The position counters are 10 bits wide, so neither total may exceed 1024.
    generate
        if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_total_too_large
            $error("vga_timing_gen: H_TOTAL and V_TOTAL must both be <= 1024");
        end
    endgenerate

    localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS_END  = 10'(H_ACTIVE);
    localparam logic [9:0] V_VIS_END  = 10'(V_ACTIVE);
    localparam logic [9:0] HS_START   = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_END     = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] VS_START   = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_END     = 10'(V_ACTIVE + V_FP + V_SYNC);

    logic [9:0] h_next;
    logic [9:0] v_next;
    logic       hsync_next;
    logic       vsync_next;
    logic       display_next;

    // Position the raster moves to on the next enabled edge.
    always_comb begin
        h_next = hpos + 10'd1;
        v_next = vpos;
        if (hpos == H_LAST) begin
            h_next = 10'd0;
            v_next = (vpos == V_LAST) ? 10'd0 : vpos + 10'd1;
        end
    end

    // Flags for the next position, so the registered flags carry zero skew
    // relative to the registered counters.
    always_comb begin
        hsync_next   = (h_next >= HS_START && h_next < HS_END) ? HSYNC_POL : ~HSYNC_POL;
        vsync_next   = (v_next >= VS_START && v_next < VS_END) ? VSYNC_POL : ~VSYNC_POL;
        display_next = (h_next < H_VIS_END) && (v_next < V_VIS_END);
    end

    // Reset parks the raster on the last pixel of the frame, so the first
    // enabled edge afterwards is an ordinary wrap into (0,0).
    always_ff @(posedge clk) begin
        if (rst) begin
            hpos       <= H_LAST;
            vpos       <= V_LAST;
            hsync      <= ~HSYNC_POL;
            vsync      <= ~VSYNC_POL;
            display_on <= 1'b0;
        end else if (en) begin
            hpos       <= h_next;
            vpos       <= v_next;
            hsync      <= hsync_next;
            vsync      <= vsync_next;
            display_on <= display_next;
        end
    end

    // Strobes fire only on the enabled edge that loads the new position and
    // drop on the following edge whatever en does, keeping them one clock wide.
    always_ff @(posedge clk) begin
        if (rst) begin
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else if (en) begin
            line_start  <= (h_next == 10'd0);
            frame_start <= (h_next == 10'd0) && (v_next == 10'd0);
        end else begin
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen
// Directed bench for vga_timing_gen. Two instances share clock, reset and
// enable: one with the real 640x480 timing and one shrunk to a 16x11 raster
// with positive sync polarity so that whole frames fit in a short run.
// Expected outputs come from the count of enabled edges since reset: after
// n enabled edges the raster sits at pixel (n-1) of the frame.

module tb_vga_timing_gen;

    logic       clk;
    logic       rst;
    logic       en;

    logic [9:0] hpos_a, vpos_a;
    logic       hsync_a, vsync_a, display_on_a, line_start_a, frame_start_a;
    logic [9:0] hpos_b, vpos_b;
    logic       hsync_b, vsync_b, display_on_b, line_start_b, frame_start_b;

    int passed;
    int total;
    int n_edges;
    bit last_edge_enabled;

    vga_timing_gen dut_a (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .hpos        (hpos_a),
        .vpos        (vpos_a),
        .hsync       (hsync_a),
        .vsync       (vsync_a),
        .display_on  (display_on_a),
        .line_start  (line_start_a),
        .frame_start (frame_start_a)
    );

    // Small raster: H 8+2+3+3 = 16, hsync at 10..12; V 6+1+2+2 = 11, vsync at 7..8.
    vga_timing_gen #(
        .H_ACTIVE (8), .H_FP (2), .H_SYNC (3), .H_BP (3),
        .V_ACTIVE (6), .V_FP (1), .V_SYNC (2), .V_BP (2),
        .HSYNC_POL (1'b1), .VSYNC_POL (1'b1)
    ) dut_b (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .hpos        (hpos_b),
        .vpos        (vpos_b),
        .hsync       (hsync_b),
        .vsync       (vsync_b),
        .display_on  (display_on_b),
        .line_start  (line_start_b),
        .frame_start (frame_start_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive inputs, take one clock edge, then settle before sampling.
    task automatic applyStimulus(input logic r, input logic e);
        rst = r;
        en  = e;
        @(posedge clk);
        #1;
        if (r) begin
            n_edges           = 0;
            last_edge_enabled = 1'b0;
        end else begin
            if (e) n_edges++;
            last_edge_enabled = e;
        end
    endtask

    task automatic compare(input string tag, input logic [9:0] got, input logic [9:0] exp);
        total++;
        assert (got === exp) passed++;
        else $error("[TB] FAIL %s (edge %0d): got %0d, expected %0d", tag, n_edges, got, exp);
    endtask

    // Expected outputs of one instance, derived from the enabled-edge count.
    task automatic checkInstance(
        input string name,
        input int ht, input int vt, input int ha, input int va,
        input int hs0, input int hs1, input int vs0, input int vs1, input bit pol,
        input logic [9:0] hp, input logic [9:0] vp,
        input logic hs, input logic vs, input logic de, input logic ls, input logic fs);
        int pix, eh, ev;
        logic exp_hs, exp_vs, exp_de, exp_ls, exp_fs;
        if (n_edges == 0) pix = ht * vt - 1;
        else pix = (n_edges - 1) % (ht * vt);
        eh = pix % ht;
        ev = pix / ht;
        exp_hs = (eh >= hs0 && eh < hs1) ? pol : ~pol;
        exp_vs = (ev >= vs0 && ev < vs1) ? pol : ~pol;
        exp_de = (eh < ha) && (ev < va);
        exp_ls = last_edge_enabled && (eh == 0);
        exp_fs = last_edge_enabled && (eh == 0) && (ev == 0);
        compare({name, ".hpos"}, hp, 10'(eh));
        compare({name, ".vpos"}, vp, 10'(ev));
        compare({name, ".hsync"}, {9'd0, hs}, {9'd0, exp_hs});
        compare({name, ".vsync"}, {9'd0, vs}, {9'd0, exp_vs});
        compare({name, ".display_on"}, {9'd0, de}, {9'd0, exp_de});
        compare({name, ".line_start"}, {9'd0, ls}, {9'd0, exp_ls});
        compare({name, ".frame_start"}, {9'd0, fs}, {9'd0, exp_fs});
    endtask

    task automatic checkOutput();
        checkInstance("a", 800, 525, 640, 480, 656, 752, 490, 492, 1'b0,
                      hpos_a, vpos_a, hsync_a, vsync_a, display_on_a, line_start_a, frame_start_a);
        checkInstance("b", 16, 11, 8, 6, 10, 13, 7, 9, 1'b1,
                      hpos_b, vpos_b, hsync_b, vsync_b, display_on_b, line_start_b, frame_start_b);
    endtask

    initial begin
        passed            = 0;
        total             = 0;
        n_edges           = 0;
        last_edge_enabled = 1'b0;
        rst               = 1'b1;
        en                = 1'b1;

        // Reset state: parked at the last pixel, syncs deasserted.
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b1);
        checkOutput();
        compare("reset.hpos_799", hpos_a, 10'd799);
        compare("reset.vpos_524", vpos_a, 10'd524);
        compare("reset.hsync_b_low", {9'd0, hsync_b}, 10'd0);

        // First enabled edge after release goes to (0,0) with both strobes.
        applyStimulus(1'b0, 1'b1);
        checkOutput();
        compare("first.hpos", hpos_a, 10'd0);
        compare("first.frame_start", {9'd0, frame_start_a}, 10'd1);
        compare("first.display_on", {9'd0, display_on_a}, 10'd1);
        applyStimulus(1'b0, 1'b1);
        checkOutput();
        compare("second.hpos", hpos_a, 10'd1);
        compare("second.line_start", {9'd0, line_start_a}, 10'd0);

        // Continuous enable: covers line 0 of the real raster (display edge
        // at 640, hsync 656..751, next line_start at 800) and several full
        // frames of the small raster including vsync and the frame wrap.
        for (int i = 0; i < 1000; i++) begin
            applyStimulus(1'b0, 1'b1);
            checkOutput();
        end
        compare("line1.vpos", vpos_a, 10'd1);

        // Enable toggled every clock: state holds, strobes stay one clock wide.
        for (int i = 0; i < 400; i++) begin
            applyStimulus(1'b0, (i % 2) == 1);
            checkOutput();
        end

        // Mid-frame reset.
        applyStimulus(1'b1, 1'b1);
        checkOutput();
        compare("midreset.vpos", vpos_a, 10'd524);
        applyStimulus(1'b0, 1'b1);
        checkOutput();
        compare("midreset.frame_start", {9'd0, frame_start_a}, 10'd1);

        // Reset dominates a low enable.
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b0, 1'b1);
            checkOutput();
        end
        applyStimulus(1'b1, 1'b0);
        checkOutput();
        compare("reset_en0.hpos", hpos_a, 10'd799);
        applyStimulus(1'b0, 1'b0);
        checkOutput();
        for (int i = 0; i < 200; i++) begin
            applyStimulus(1'b0, 1'b1);
            checkOutput();
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
